atr_sector_reader: RTL
======================

Name: atr_sector_reader

Overview:
- Converts an Atari SIO disk-sector request (drive, sector number, sector size) into one or two 512-byte SD block reads through the hps_io sd_* interface.
- Streams exactly one sector's bytes to the consumer with valid/ready flow control.
- Sits between hps_io (upstream) and the SIO drive emulation (downstream). Replaces per-byte CPU copying of ATR sectors.

Parameters:
- NDRV, 2, number of drives; width of sd_rd and of the mounted/size tables.
- HDR_BYTES, 16, ATR header length skipped before sector 1.

Ports:
- clk_sys  in  1  system clock
- areset  in  1  reset, synchronous, active-high
- req  in  1  start pulse; sampled only in IDLE
- drive  in  $clog2(NDRV)  drive index for req
- sector  in  16  ATR sector number, 1-based
- dd  in  1  1 = double density (256-byte sectors from sector 4 up)
- busy  out  1  high from accepted req until done/err
- done  out  1  1-cycle pulse after the last byte is accepted
- err  out  1  1-cycle pulse on a rejected request
- out_valid  out  1  byte available
- out_ready  in  1  consumer accepts when valid & ready
- out_data  out  8  sector byte
- out_last  out  1  marks the final byte of the sector
- img_mounted  in  NDRV  hps_io mount strobes
- img_size  in  32  image size, latched on a mount strobe
- sd_lba  out  32  block address
- sd_rd  out  NDRV  read request, one-hot on drive
- sd_ack  in  1  hps_io acknowledge
- sd_buff_addr  in  9  write address into the block buffer
- sd_buff_dout  in  8  block data
- sd_buff_wr  in  1  block buffer write strobe

Behaviour:
- Reset values: busy, done, err, out_valid, out_last, and sd_rd are 0; sd_lba is 0; out_data is 0; the size table and mounted flags are 0; state is IDLE.
- Mount handling: on img_mounted[i], mounted[i] is set to (img_size != 0) and size[i] is set to img_size. Mount strobes during a transfer are latched but do not abort it.
- Sector length: len = 256 if dd and sector >= 4, otherwise 128.
- Byte offset (32-bit arithmetic, no truncation before the add):
  - sector <= 3 or !dd: HDR + (sector-1)*128
  - dd and sector >= 4: HDR + 384 + (sector-4)*256
- States:
  - IDLE: on req, latch inputs, set busy, go to CALC.
  - CALC (1 cycle): compute offset and len.
  - CHECK: error if sector == 0, if the drive is not mounted, or if offset + len > size[drive]. On error, pulse err, clear busy, return to IDLE. Otherwise set lba = offset[31:9], idx = offset[8:0], rem = len, go to RQ.
  - RQ: drive sd_lba = lba and sd_rd[drive] = 1. Hold until sd_ack = 1, then clear sd_rd and go to WT.
  - WT: wait for sd_ack to fall (a 1->0 edge), then go to ST.
  - ST: read buffer[idx]. The buffer has 1-cycle read latency, so out_valid rises 2 cycles after entering ST. On each handshake, idx++ and rem--.
    - When rem reaches 0: pulse done in the cycle after the last handshake, clear busy, go to IDLE.
    - When idx wraps 511 -> 0 with rem != 0: lba++, go to RQ.
- Spanning: a sector crosses a block boundary when idx + len > 512. Example: SD sector 4, 128-byte → offset 400, 112 bytes from block 0 and 16 from block 1.
- Stream rules:
  - out_data and out_last are held stable while out_valid & !out_ready.
  - No bubbles within a block when out_ready stays high.
  - out_last is high only together with the final byte.
- Buffer: single 512x8 buffer. Written only by sd_buff_wr while sd_ack is high; read only in ST.
- areset mid-transfer: return to IDLE, drop sd_rd, drop out_valid. A pending sd_ack is ignored.
- A req while busy is ignored.

Optional Feature:
- Macro: ATR_CACHE_EN.
- When defined: the reader keeps tag {valid, drive, lba} for the buffered block. RQ/WT is skipped, going straight to ST, when the tag matches. The tag is cleared by areset or by any img_mounted bit; it is set after each completed WT.
- When undefined: every block is fetched from SD.

Decomposition:
- Package atr_pkg:
  - state enum
  - HDR_BYTES
  - SEC_SD = 128, SEC_DD = 256, BLK = 512
  - offset function
- One sub-module: atr_blkbuf, a 512x8 simple dual-port RAM with registered read.

Test Plan:
- Mount drive 0 with size 92176, request sector 1 (single density) → one sd_rd[0] with sd_lba = 0; 128 bytes from buffer 16..143; out_last on byte 128; done pulse.
- Sector 4 (single density) → sd_lba 0, then sd_lba 1; bytes from buffer 400..511, then 0..15; exactly 2 sd_rd pulses.
- Double density, sector 5, size 183952 → offset 656, sd_lba 1, idx 144, 256 bytes in one block.
- Sector 0, an unmounted drive, or offset + len > size → err pulse within 3 cycles; no sd_rd.
- Random out_ready throttling during sector 4 → byte sequence identical to the unthrottled run; data held stable while stalled.
- areset asserted during WT → all outputs reach reset values the next cycle; a following req for sector 1 completes normally.
- With ATR_CACHE_EN: two consecutive requests to sectors 1 and 2 → only the first issues sd_rd; an img_mounted strobe forces a re-fetch.

Source files
------------

// File: rtl/atr_pkg.sv
// atr_pkg: shared state encoding, ATR geometry constants and the sector-offset helper.
package atr_pkg;
    typedef enum logic [2:0] {IDLE, CALC, CHECK, RQ, WT, ST} state_t;
    localparam int HDR_BYTES = 16;
    localparam int SEC_SD = 128;
    localparam int SEC_DD = 256;
    localparam int BLK = 512;
    // The first three sectors stay 128 bytes even on double-density images
    function automatic logic [31:0] atr_offset(input logic [31:0] hdr, input logic [15:0] sector, input logic dd);
        logic [31:0] s;
        s = {16'd0, sector};
        return (dd && sector >= 16'd4) ? hdr + 32'(3 * SEC_SD) + ((s - 32'd4) << 8) : hdr + ((s - 32'd1) << 7);
    endfunction
endpackage

// File: rtl/atr_sector_reader_blkbuf.sv
// atr_blkbuf: 512x8 simple dual-port block buffer with an enabled, registered read port.
module atr_blkbuf
    import atr_pkg::*;
(
    input  logic       clk_sys,
    input  logic       we,
    input  logic [8:0] waddr,
    input  logic [7:0] wdata,
    input  logic       re,
    input  logic [8:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [0:BLK-1];
    always_ff @(posedge clk_sys) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/atr_sector_reader.sv
// atr_sector_reader: turns an ATR sector request into hps_io sd_* block reads and streams the sector out.
// Define ATR_CACHE_EN to keep a one-block tag so requests hitting the buffered block skip the SD fetch.
module atr_sector_reader #(
    parameter int NDRV = 2,
    parameter int HDR_BYTES = atr_pkg::HDR_BYTES
) (
    input  logic                     clk_sys,
    input  logic                     areset,
    input  logic                     req,
    input  logic [$clog2(NDRV)-1:0]  drive,
    input  logic [15:0]              sector,
    input  logic                     dd,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_last,
    input  logic [NDRV-1:0]          img_mounted,
    input  logic [31:0]              img_size,
    output logic [31:0]              sd_lba,
    output logic [NDRV-1:0]          sd_rd,
    input  logic                     sd_ack,
    input  logic [8:0]               sd_buff_addr,
    input  logic [7:0]               sd_buff_dout,
    input  logic                     sd_buff_wr
);
    import atr_pkg::*;
    state_t state, nxt;
    logic [$clog2(NDRV)-1:0] drv;
    logic [15:0] sec;
    logic ddr;
    logic [31:0] off;
    logic [8:0] len, idx, crem;
    logic [22:0] lba;
    logic [NDRV-1:0] mounted;
    logic [31:0] size_tbl [NDRV];
    logic ack_q, arm, wrapped, bad, hs, rd_en, last_hs, blk_hs, enter_st, hit;
    logic [7:0] q;

    // crem counts bytes not yet consumed; one of them may already sit in the RAM output register
    assign hs = out_valid && out_ready;
    assign rd_en = state == ST && arm && !wrapped && crem > {8'd0, out_valid} && (!out_valid || out_ready);
    assign last_hs = hs && crem == 9'd1;
    assign blk_hs = hs && wrapped && crem != 9'd1;
    assign bad = sec == 16'd0 || !mounted[drv] || {1'b0, off} + {24'd0, len} > {1'b0, size_tbl[drv]};
    assign enter_st = nxt == ST && (state != ST || blk_hs);
    assign busy = state != IDLE;
    assign sd_rd = (state == RQ) ? (NDRV'(1) << drv) : '0;
    assign sd_lba = {9'd0, lba};
    assign out_data = out_valid ? q : 8'd0;
    assign out_last = out_valid && crem == 9'd1;

`ifdef ATR_CACHE_EN
    logic tag_v;
    logic [$clog2(NDRV)-1:0] tag_drv;
    logic [22:0] tag_lba, new_lba;
    assign new_lba = (state == CHECK) ? off[31:9] : lba + 23'd1;
    assign hit = tag_v && tag_drv == drv && tag_lba == new_lba;
    always_ff @(posedge clk_sys) begin
        if (areset || |img_mounted) tag_v <= 1'b0;
        else if (state == WT && nxt == ST) begin
            tag_v <= 1'b1;
            tag_drv <= drv;
            tag_lba <= lba;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk_sys) state <= areset ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req ? CALC : IDLE;
            CALC:    nxt = CHECK;
            CHECK:   nxt = bad ? IDLE : (hit ? ST : RQ);
            RQ:      nxt = sd_ack ? WT : RQ;
            WT:      nxt = (ack_q && !sd_ack) ? ST : WT;
            ST:      nxt = last_hs ? IDLE : (blk_hs ? (hit ? ST : RQ) : ST);
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (areset) begin
            drv <= '0;
            sec <= '0;
            ddr <= 1'b0;
            off <= '0;
            len <= '0;
            idx <= '0;
            crem <= '0;
            lba <= '0;
            ack_q <= 1'b0;
            arm <= 1'b0;
            wrapped <= 1'b0;
            out_valid <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            mounted <= '0;
            for (int i = 0; i < NDRV; i++) size_tbl[i] <= '0;
        end else begin
            if (state == IDLE && req) begin
                drv <= drive;
                sec <= sector;
                ddr <= dd;
            end
            if (state == CALC) begin
                off <= atr_offset(32'(HDR_BYTES), sec, ddr);
                len <= (ddr && sec >= 16'd4) ? 9'(SEC_DD) : 9'(SEC_SD);
            end
            if (state == CHECK && !bad) begin
                lba <= off[31:9];
                idx <= off[8:0];
                crem <= len;
            end
            if (blk_hs) lba <= lba + 23'd1;
            if (rd_en) idx <= idx + 9'd1;
            if (hs) crem <= crem - 9'd1;
            ack_q <= sd_ack;
            // first ST cycle only primes; the read issues one cycle later
            arm <= nxt == ST && !enter_st;
            wrapped <= enter_st ? 1'b0 : (wrapped || (rd_en && idx == 9'd511));
            out_valid <= rd_en ? 1'b1 : (hs ? 1'b0 : out_valid);
            done <= state == ST && last_hs;
            err <= state == CHECK && bad;
            for (int i = 0; i < NDRV; i++)
                if (img_mounted[i]) begin
                    mounted[i] <= img_size != 32'd0;
                    size_tbl[i] <= img_size;
                end
        end
    end

    atr_blkbuf u_buf (
        .clk_sys(clk_sys),
        .we(sd_buff_wr && sd_ack),
        .waddr(sd_buff_addr),
        .wdata(sd_buff_dout),
        .re(rd_en),
        .raddr(idx),
        .rdata(q)
    );
endmodule
